coprosit_writeback: RTL and testbench

//  Writeback and scoreboard stage directly upstream of the Coprosit posit register file.
//  - Collects results from NR_SRC posit functional units and round-robin arbitrates them onto
//    the register file's single write port, registered.
//  - Keeps a 32-entry busy scoreboard: set at issue, cleared when the result is written back.
//  - Gives the issue stage RAW/WAW stall information.

---
 rtl/coprosit_pkg.sv | 14 +
 rtl/coprosit_writeback_if.sv | 15 +
 rtl/coprosit_rr_arbiter.sv | 45 ++++
 rtl/coprosit_writeback.sv | 93 +++++++++
 tb/tb_coprosit_writeback.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coprosit_pkg.sv
// Shared types and constants for the Coprosit writeback stage.
// The register file is 32 posit registers wide-addressed by 5 bits.
package coprosit_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int POSIT_W    = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [POSIT_W-1:0]    data;
    } coprosit_wb_req_t;

endpackage

// File: rtl/coprosit_writeback_if.sv
// Result bus from the posit functional units into the writeback stage.
// Valid/ready: a source raises res_valid[k] with addr/data stable and may not retract;
// the transfer happens at the clock edge where res_valid[k] & res_ready[k] are both high.
interface coprosit_writeback_if #(
    parameter int NR_SRC     = 2,
    parameter int DATA_WIDTH = 32
);
    logic [NR_SRC-1:0]            res_valid;
    logic [NR_SRC-1:0]            res_ready;
    logic [NR_SRC*5-1:0]          res_addr;
    logic [NR_SRC*DATA_WIDTH-1:0] res_data;

    modport master (output res_valid, output res_addr, output res_data, input res_ready);
    modport slave  (input res_valid, input res_addr, input res_data, output res_ready);
endinterface

// File: rtl/coprosit_rr_arbiter.sv
// Round-robin arbiter: scans from the rotating pointer and grants the first valid requester.
// The pointer moves one past the winner after every grant and holds when idle.
module coprosit_rr_arbiter #(
    parameter  int NR_SRC = 2,
    localparam int IDX_W  = (NR_SRC > 1) ? $clog2(NR_SRC) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NR_SRC-1:0] valid_i,
    output logic [NR_SRC-1:0] grant_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              gnt_valid_o
);

    logic [IDX_W-1:0] ptr_q;
    logic             found;
    int               cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < NR_SRC; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NR_SRC) cand = cand - NR_SRC;
            if (!found && valid_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IDX_W'(cand);
            end
        end
    end

    assign gnt_valid_o = found;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= (int'(idx_o) == NR_SRC - 1) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/coprosit_writeback.sv
// Writeback stage: arbitrates unit results onto the single register-file write port
// and keeps the busy scoreboard that gates issue on RAW/WAW hazards.
module coprosit_writeback
    import coprosit_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NR_SRC        = 2,
    parameter int NR_READ_PORTS = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              issue_valid_i,
    output logic                              issue_ready_o,
    input  logic [REG_ADDR_W-1:0]             issue_rd_i,
    input  logic [NR_READ_PORTS*REG_ADDR_W-1:0] issue_rs_i,
    input  logic [NR_READ_PORTS-1:0]          issue_rs_valid_i,
    coprosit_writeback_if.slave               res,
    output logic                              we_o,
    output logic [REG_ADDR_W-1:0]             waddr_o,
    output logic [DATA_WIDTH-1:0]             wdata_o,
    output logic [NUM_REGS-1:0]               busy_o,
    input  logic                              flush_i
);

    localparam int IDX_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

    logic [NR_SRC-1:0] gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_valid;

    coprosit_wb_req_t  sel_req;
    coprosit_wb_req_t  wb_q;
    logic              we_q;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic              rs_hit;
    logic              issue_fire;

    coprosit_rr_arbiter #(.NR_SRC(NR_SRC)) u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (res.res_valid),
        .grant_o     (gnt),
        .idx_o       (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign res.res_ready = gnt;

    // DATA_WIDTH is expected to equal POSIT_W, the register-file word.
    always_comb begin
        sel_req.addr = res.res_addr[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
        sel_req.data = res.res_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        rs_hit = 1'b0;
        for (int j = 0; j < NR_READ_PORTS; j++) begin
            if (issue_rs_valid_i[j] && busy_q[issue_rs_i[j*REG_ADDR_W +: REG_ADDR_W]]) begin
                rs_hit = 1'b1;
            end
        end
    end

    assign issue_ready_o = ~busy_q[issue_rd_i] & ~rs_hit & ~flush_i;
    assign issue_fire    = issue_valid_i & issue_ready_o;

    // Clear of the register being written happens first so a same-cycle issue to it wins.
    always_comb begin
        busy_d = busy_q;
        if (we_q)       busy_d[wb_q.addr]  = 1'b0;
        if (issue_fire) busy_d[issue_rd_i] = 1'b1;
        if (flush_i)    busy_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            we_q   <= 1'b0;
            wb_q   <= '0;
            busy_q <= '0;
        end else begin
            we_q   <= gnt_valid;
            if (gnt_valid) wb_q <= sel_req;
            busy_q <= busy_d;
        end
    end

    assign we_o    = we_q;
    assign waddr_o = wb_q.addr;
    assign wdata_o = wb_q.data;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_coprosit_writeback.sv
// Directed bench for coprosit_writeback with a reference model and result scoreboard.
module tb_coprosit_writeback;

  localparam int NR  = 2;
  localparam int DW  = 32;
  localparam int NRP = 2;

  logic            clk;
  logic            rst_ni;
  logic            issue_valid;
  logic            issue_ready;
  logic [4:0]      issue_rd;
  logic [NRP*5-1:0] issue_rs;
  logic [NRP-1:0]  issue_rs_valid;
  logic            we;
  logic [4:0]      waddr;
  logic [DW-1:0]   wdata;
  logic [31:0]     busy;
  logic            flush;

  coprosit_writeback_if #(.NR_SRC(NR), .DATA_WIDTH(DW)) res_if ();

  coprosit_writeback #(.DATA_WIDTH(DW), .NR_SRC(NR), .NR_READ_PORTS(NRP)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .issue_valid_i    (issue_valid),
    .issue_ready_o    (issue_ready),
    .issue_rd_i       (issue_rd),
    .issue_rs_i       (issue_rs),
    .issue_rs_valid_i (issue_rs_valid),
    .res              (res_if.slave),
    .we_o             (we),
    .waddr_o          (waddr),
    .wdata_o          (wdata),
    .busy_o           (busy),
    .flush_i          (flush)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and model state
  logic [36:0] src_q[NR][$];
  logic [36:0] exp_q[$];
  logic [36:0] m_last;
  logic [31:0] m_busy;
  logic        m_we;
  int          m_ptr;
  int          n_vec;
  int          n_err;
  logic        obs_ready;

  function automatic logic [36:0] mk(input logic [4:0] a, input logic [31:0] d);
    return {a, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_srcs();
    for (int k = 0; k < NR; k++) begin
      if (src_q[k].size() != 0) begin
        res_if.res_valid[k]          = 1'b1;
        res_if.res_addr[k*5 +: 5]    = src_q[k][0][36:32];
        res_if.res_data[k*DW +: DW]  = src_q[k][0][31:0];
      end else begin
        res_if.res_valid[k]          = 1'b0;
        res_if.res_addr[k*5 +: 5]    = '0;
        res_if.res_data[k*DW +: DW]  = '0;
      end
    end
  endtask

  // one clock: check combinational outputs, advance the model, check registered outputs
  task automatic cycle();
    logic [NR-1:0] mg;
    int            g;
    int            c;
    logic          mrdy;
    logic [31:0]   nb;
    logic [36:0]   item;
    drive_srcs();
    #1;
    mg = '0;
    g  = -1;
    for (int i = 0; i < NR; i++) begin
      c = (m_ptr + i) % NR;
      if (g < 0 && src_q[c].size() != 0) begin
        g     = c;
        mg[c] = 1'b1;
      end
    end
    chk("res_ready", 64'(res_if.res_ready), 64'(mg));
    mrdy = !m_busy[issue_rd] && !flush;
    for (int j = 0; j < NRP; j++)
      if (issue_rs_valid[j] && m_busy[issue_rs[j*5 +: 5]]) mrdy = 1'b0;
    obs_ready = issue_ready;
    chk("issue_ready", 64'(issue_ready), 64'(mrdy));
    if (!rst_ni) begin
      @(posedge clk);
      #1;
      m_ptr  = 0;
      m_busy = '0;
      m_we   = 1'b0;
      m_last = '0;
      exp_q.delete();
      chk("rst_we", 64'(we), 64'(0));
      chk("rst_waddr", 64'(waddr), 64'(0));
      chk("rst_wdata", 64'(wdata), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
    end else begin
      nb = m_busy;
      if (m_we) nb[m_last[36:32]] = 1'b0;
      if (issue_valid && mrdy) nb[issue_rd] = 1'b1;
      if (flush) nb = '0;
      if (g >= 0) begin
        item = src_q[g].pop_front();
        exp_q.push_back(item);
        m_ptr = (g + 1) % NR;
      end
      @(posedge clk);
      #1;
      m_busy = nb;
      m_we   = (g >= 0);
      chk("we", 64'(we), 64'(m_we));
      if (m_we) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $error("FAIL scoreboard_empty: observed write expected none");
        end else begin
          m_last = exp_q.pop_front();
        end
      end
      chk("waddr", 64'(waddr), 64'(m_last[36:32]));
      chk("wdata", 64'(wdata), 64'(m_last[31:0]));
      chk("busy", 64'(busy), 64'(m_busy));
    end
  endtask

  // directed sequence
  initial begin
    logic [3:0] wv;
    n_vec = 0;
    n_err = 0;
    m_ptr = 0;
    m_busy = '0;
    m_we = 1'b0;
    m_last = '0;
    rst_ni = 1'b0;
    issue_valid = 1'b0;
    issue_rd = '0;
    issue_rs = '0;
    issue_rs_valid = '0;
    flush = 1'b0;
    res_if.res_valid = '0;
    res_if.res_addr = '0;
    res_if.res_data = '0;
    @(posedge clk);
    #1;

    // reset with both sources valid: pointer 0 grants src0, nothing is written
    src_q[0].push_back(mk(5'd1, 32'h1111_0001));
    src_q[1].push_back(mk(5'd2, 32'h2222_0002));
    cycle();
    chk("rst_ready01", 64'(res_if.res_ready), 64'(2'b01));
    cycle();
    rst_ni = 1'b1;
    cycle();
    chk("src0_first", 64'(waddr), 64'(5'd1));
    cycle();
    chk("src1_second", 64'(waddr), 64'(5'd2));
    cycle();
    chk("idle_we", 64'(we), 64'(0));

    // continuous contention: grants alternate 0,1,0,1 with back-to-back writes
    src_q[0].push_back(mk(5'd10, 32'hA0A0_0010));
    src_q[0].push_back(mk(5'd11, 32'hA0A0_0011));
    src_q[1].push_back(mk(5'd12, 32'hB0B0_0012));
    src_q[1].push_back(mk(5'd13, 32'hB0B0_0013));
    wv = '0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      wv[i] = we;
    end
    chk("we_run", 64'(wv), 64'(4'hF));
    chk("last_of_run", 64'(waddr), 64'(5'd13));
    cycle();

    // single result, one-cycle write latency then idle
    src_q[0].push_back(mk(5'd3, 32'h4000_0000));
    cycle();
    chk("single_we", 64'(we), 64'(1));
    chk("single_waddr", 64'(waddr), 64'(5'd3));
    chk("single_wdata", 64'(wdata), 64'(32'h4000_0000));
    cycle();
    chk("single_we_drop", 64'(we), 64'(0));
    chk("hold_waddr", 64'(waddr), 64'(5'd3));

    // RAW stall on r5 until the cycle after its write
    issue_valid = 1'b1;
    issue_rd = 5'd5;
    cycle();
    chk("busy5_set", 64'(busy[5]), 64'(1));
    issue_rd = 5'd8;
    issue_rs = {5'd0, 5'd5};
    issue_rs_valid = 2'b01;
    cycle();
    chk("raw_stall0", 64'(obs_ready), 64'(0));
    src_q[0].push_back(mk(5'd5, 32'h3C00_0005));
    cycle();
    chk("raw_stall_accept", 64'(obs_ready), 64'(0));
    cycle();
    chk("raw_stall_wecycle", 64'(obs_ready), 64'(0));
    cycle();
    chk("raw_issue", 64'(obs_ready), 64'(1));
    chk("busy8_set", 64'(busy[8]), 64'(1));
    chk("busy5_clr", 64'(busy[5]), 64'(0));
    issue_valid = 1'b0;
    issue_rs_valid = '0;

    // issue to r7 in the same cycle r7 is written: set wins
    src_q[1].push_back(mk(5'd7, 32'h7777_0007));
    cycle();
    issue_valid = 1'b1;
    issue_rd = 5'd7;
    chk("we7_now", 64'(waddr), 64'(5'd7));
    cycle();
    issue_valid = 1'b0;
    chk("busy7_kept", 64'(busy[7]), 64'(1));
    cycle();
    chk("busy7_stays", 64'(busy[7]), 64'(1));

    // flush with a write in flight
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_pre_clear", 64'(busy), 64'(0));
    issue_valid = 1'b1;
    for (int r = 4; r < 8; r++) begin
      issue_rd = 5'(r);
      if (r == 7) src_q[1].push_back(mk(5'd20, 32'h2020_0020));
      cycle();
    end
    chk("busy_f0", 64'(busy), 64'(32'h0000_00F0));
    chk("inflight_we", 64'(we), 64'(1));
    src_q[0].push_back(mk(5'd21, 32'h2121_0021));
    flush = 1'b1;
    issue_rd = 5'd9;
    cycle();
    chk("flush_ready0", 64'(obs_ready), 64'(0));
    chk("flush_busy0", 64'(busy), 64'(0));
    chk("flush_arb_we", 64'(we), 64'(1));
    chk("flush_arb_waddr", 64'(waddr), 64'(5'd21));
    flush = 1'b0;
    issue_valid = 1'b0;
    cycle();
    chk("post_flush_busy", 64'(busy), 64'(0));
    chk("post_flush_we", 64'(we), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // report
  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: observed no end of sequence expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
